dcache_port_arbiter: RTL and testbench

- Shares the single data-cache port (enable, rw, address, write data, read data, hit) between two requesters.
- Requester 0 is the stage-1 controller (MAR/MDR path). Requester 1 is an auxiliary master, e.g. an input-device DMA or interrupt context save.
- Sequences each access through a small FSM: arbitrate, issue, wait for hit or miss fill, acknowledge.
- Sits between the requesters and the cache block's ch_en/ch_rw/mar/mdr inputs.

---
 rtl/dcache_port_arbiter.sv | 132 +++++++++++++
 tb/tb_dcache_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter.sv
// Two-requester arbiter for the single data-cache port: IDLE -> ISSUE -> WAIT -> DONE per access.
// Define ARB_FIXED_PRI_EN to give requester 0 fixed priority instead of round-robin.
module dcache_port_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MISS_LAT = 3
) (
    input  logic          g_clk,
    input  logic          g_clr,
    input  logic          r0_req,
    input  logic          r0_rw,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_rw,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic [DW-1:0] r1_rdata,
    output logic          ch_en,
    output logic          ch_rw,
    output logic [AW-1:0] ch_addr,
    output logic [DW-1:0] ch_wdata,
    input  logic [DW-1:0] ch_rdata,
    input  logic          ch_hit,
    output logic          busy,
    output logic          grant_id
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_LAT);

    state_t        state;
    state_t        next_state;
    logic          grant_now;
    logic          win;
    logic          lat_rw;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [3:0]    miss_cnt;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          capture;
`ifndef ARB_FIXED_PRI_EN
    // Requester favoured on the next simultaneous request; reset favours requester 0.
    logic          rr_ptr;
`endif

    always_comb begin
        next_state = state;
        grant_now  = 1'b0;
        win        = grant_id;
        case (state)
            S_IDLE: begin
                if (r0_req || r1_req) begin
                    grant_now  = 1'b1;
                    next_state = S_ISSUE;
`ifdef ARB_FIXED_PRI_EN
                    win = r0_req ? 1'b0 : 1'b1;
`else
                    if (r0_req && r1_req) win = rr_ptr;
                    else                  win = r1_req;
`endif
                end
            end
            S_ISSUE: next_state = S_WAIT;
            S_WAIT: begin
                if (ch_hit || (miss_cnt == MISS_LIM)) next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Read data is taken on the edge leaving WAIT so it is already valid while ack is high.
    assign capture = (state == S_WAIT) && (next_state == S_DONE) && !lat_rw;

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state     <= S_IDLE;
            grant_id  <= 1'b0;
            lat_rw    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            miss_cnt  <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifndef ARB_FIXED_PRI_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (grant_now) begin
                grant_id  <= win;
                lat_rw    <= win ? r1_rw    : r0_rw;
                lat_addr  <= win ? r1_addr  : r0_addr;
                lat_wdata <= win ? r1_wdata : r0_wdata;
            end
            if (state == S_ISSUE) begin
                miss_cnt <= '0;
            end else if (state == S_WAIT && !ch_hit && miss_cnt != MISS_LIM) begin
                miss_cnt <= miss_cnt + 4'd1;
            end
            if (capture) begin
                if (grant_id) rdata1 <= ch_rdata;
                else          rdata0 <= ch_rdata;
            end
`ifndef ARB_FIXED_PRI_EN
            if (state == S_DONE) rr_ptr <= ~grant_id;
`endif
        end
    end

    assign ch_en    = (state == S_ISSUE) || (state == S_WAIT);
    assign ch_rw    = lat_rw;
    assign ch_addr  = lat_addr;
    assign ch_wdata = lat_wdata;
    assign r0_ack   = (state == S_DONE) && !grant_id;
    assign r1_ack   = (state == S_DONE) && grant_id;
    assign r0_rdata = rdata0;
    assign r1_rdata = rdata1;
    assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter: directed scenarios plus randomized traffic against a cycle-age model.
module tb_dcache_port_arbiter;

    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int MISS_LAT = 3;

    logic          g_clk = 1'b0;
    logic          g_clr = 1'b0;
    logic          r0_req = 1'b0, r0_rw = 1'b0;
    logic [AW-1:0] r0_addr = '0;
    logic [DW-1:0] r0_wdata = '0;
    logic          r0_ack;
    logic [DW-1:0] r0_rdata;
    logic          r1_req = 1'b0, r1_rw = 1'b0;
    logic [AW-1:0] r1_addr = '0;
    logic [DW-1:0] r1_wdata = '0;
    logic          r1_ack;
    logic [DW-1:0] r1_rdata;
    logic          ch_en, ch_rw;
    logic [AW-1:0] ch_addr;
    logic [DW-1:0] ch_wdata;
    logic [DW-1:0] ch_rdata = '0;
    logic          ch_hit = 1'b0;
    logic          busy, grant_id;

    int checks = 0;
    int errors = 0;

    dcache_port_arbiter #(.AW(AW), .DW(DW), .MISS_LAT(MISS_LAT)) dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .ch_en(ch_en), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_rdata(ch_rdata), .ch_hit(ch_hit),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model: a transaction is described by its age in cycles since the grant edge
    // (1 = issue, 2.. = waiting) and the age at which it completes.
    bit          m_active, m_win, m_pref, m_rw;
    int          m_age, m_done_at;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata0, m_rdata1;

    always @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            m_active = 0; m_win = 0; m_pref = 0; m_rw = 0;
            m_age = 0; m_done_at = 0;
            m_addr = '0; m_wdata = '0; m_rdata0 = '0; m_rdata1 = '0;
        end else if (!m_active) begin
            if (r0_req || r1_req) begin
`ifdef ARB_FIXED_PRI_EN
                m_win = !r0_req;
`else
                m_win = (r0_req && r1_req) ? m_pref : r1_req;
`endif
                m_active = 1; m_age = 1; m_done_at = 0;
                m_rw    = m_win ? r1_rw    : r0_rw;
                m_addr  = m_win ? r1_addr  : r0_addr;
                m_wdata = m_win ? r1_wdata : r0_wdata;
            end
        end else if (m_age == m_done_at) begin
            m_active = 0;
            m_pref   = !m_win;
        end else begin
            if (m_age >= 2 && (ch_hit || (m_age - 2) == MISS_LAT)) begin
                m_done_at = m_age + 1;
                if (!m_rw) begin
                    if (m_win) m_rdata1 = ch_rdata;
                    else       m_rdata0 = ch_rdata;
                end
            end
            m_age++;
        end
    end

    function automatic bit m_in_done();
        return m_active && (m_age == m_done_at);
    endfunction

    always @(negedge g_clk) begin
        check("busy",     busy,     m_active);
        check("ch_en",    ch_en,    m_active && !m_in_done());
        check("r0_ack",   r0_ack,   m_in_done() && !m_win);
        check("r1_ack",   r1_ack,   m_in_done() && m_win);
        check("grant_id", grant_id, m_win);
        check("r0_rdata", r0_rdata, m_rdata0);
        check("r1_rdata", r1_rdata, m_rdata1);
        if (m_active && !m_in_done()) begin
            check("ch_rw",    ch_rw,    m_rw);
            check("ch_addr",  ch_addr,  m_addr);
            check("ch_wdata", ch_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic pulse_reset();
        g_clr = 1'b0;
        #2;
        g_clr = 1'b1;
    endtask

    initial begin
        int n, en_cnt, bad, k, acks;
        int got_g[4];
        int exp_g;

        // Reset values while g_clr is held low.
        #12;
        check("rst_busy",   busy,     0);
        check("rst_ch_en",  ch_en,    0);
        check("rst_ch_rw",  ch_rw,    0);
        check("rst_addr",   ch_addr,  0);
        check("rst_wdata",  ch_wdata, 0);
        check("rst_acks",   {r0_ack, r1_ack}, 0);
        check("rst_rdata",  {r0_rdata, r1_rdata}, 0);
        check("rst_grant",  grant_id, 0);
        g_clr = 1'b1;
        tick();

        // Single read hit from requester 0.
        r0_req = 1; r0_rw = 0; r0_addr = 8'h05; ch_rdata = 8'h3C; ch_hit = 1;
        n = 0; en_cnt = 0;
        do begin
            tick(); n++;
            if (ch_en) en_cnt++;
        end while (!r0_ack && n < 20);
        check("hit_latency", n, 3);
        check("hit_rdata", r0_rdata, 8'h3C);
        check("hit_en_cycles", en_cnt, 2);
        r0_req = 0; ch_hit = 0;
        tick();

        // Write miss from requester 1.
        r1_req = 1; r1_rw = 1; r1_addr = 8'h07; r1_wdata = 8'hA5;
        n = 0; en_cnt = 0; bad = 0;
        do begin
            tick(); n++;
            if (ch_en) begin
                en_cnt++;
                if (ch_rw !== 1'b1 || ch_wdata !== 8'hA5 || ch_addr !== 8'h07) bad++;
            end
        end while (!r1_ack && n < 20);
        check("miss_latency", n, 3 + MISS_LAT);
        check("miss_en_cycles", en_cnt, 2 + MISS_LAT);
        check("miss_drive_bad", bad, 0);
        check("miss_r1_rdata", r1_rdata, 0);
        r1_req = 0;
        tick();

        // Contention out of reset.
        pulse_reset();
        tick();
        r0_req = 1; r0_rw = 0; r0_addr = 8'h10;
        r1_req = 1; r1_rw = 0; r1_addr = 8'h20;
        ch_rdata = 8'h77; ch_hit = 1;
        k = 0; n = 0;
        while (k < 4 && n < 60) begin
            tick(); n++;
            if (r0_ack || r1_ack) begin
                check("cont_one_ack", r0_ack & r1_ack, 0);
                got_g[k] = r1_ack ? 1 : 0;
                k++;
                if (k == 4) begin r0_req = 0; r1_req = 0; end
            end
        end
        r0_req = 0; r1_req = 0; ch_hit = 0;
        check("cont_count", k, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRI_EN
            exp_g = 0;
`else
            exp_g = i % 2;
`endif
            check("cont_order", (i < k) ? got_g[i] : 99, exp_g);
        end
        tick();

        // Reset during WAIT abandons the access.
        r0_req = 1; r0_rw = 0; r0_addr = 8'h11;
        tick(); tick();
        check("mid_pre_busy", busy, 1);
        g_clr = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_ch_en", ch_en, 0);
        check("mid_acks", {r0_ack, r1_ack}, 0);
        check("mid_addr", ch_addr, 0);
        check("mid_grant", grant_id, 0);
        r0_req = 0;
        #1 g_clr = 1'b1;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (r0_ack || r1_ack) acks++;
        end
        check("mid_no_ack", acks, 0);

        // Request dropped during WAIT still completes once.
        r0_req = 1; r0_rw = 0; r0_addr = 8'h22; ch_rdata = 8'h5A;
        tick(); tick();
        r0_req = 0;
        acks = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (r0_ack) acks++;
        end
        check("drop_ack_once", acks, 1);
        check("drop_busy", busy, 0);
        check("drop_rdata", r0_rdata, 8'h5A);

        // Randomized traffic.
        pulse_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            ch_hit = ($urandom % 4) == 0;
            if (!m_active) ch_rdata = DW'($urandom);
            if (m_in_done() && !m_win) begin
                r0_req = $urandom % 2; r0_rw = $urandom % 2;
                r0_addr = AW'($urandom); r0_wdata = DW'($urandom);
            end else if (!r0_req) begin
                if ($urandom % 4 == 0) begin
                    r0_req = 1; r0_rw = $urandom % 2;
                    r0_addr = AW'($urandom); r0_wdata = DW'($urandom);
                end
            end else if (m_active && !m_win && $urandom % 16 == 0) begin
                r0_req = 0;
            end
            if (m_in_done() && m_win) begin
                r1_req = $urandom % 2; r1_rw = $urandom % 2;
                r1_addr = AW'($urandom); r1_wdata = DW'($urandom);
            end else if (!r1_req) begin
                if ($urandom % 4 == 0) begin
                    r1_req = 1; r1_rw = $urandom % 2;
                    r1_addr = AW'($urandom); r1_wdata = DW'($urandom);
                end
            end else if (m_active && m_win && $urandom % 16 == 0) begin
                r1_req = 0;
            end
        end
        r0_req = 0; r1_req = 0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
